// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI mode/bit-order encodings and FSM state constants shared by spi_master and spi_slave
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  typedef enum logic {
    BIT_ORDER_MSB = 1'b0,
    BIT_ORDER_LSB = 1'b1
  } bit_order_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_LEAD   = 3'd2;
  localparam logic [2:0] ST_TRAIL  = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_CS_OFF = 3'd5;

  // Data-word position of the idx-th bit on the wire for a len-bit symbol.
  function automatic logic [6:0] bit_pos(input logic order, input logic [6:0] len,
                                         input logic [6:0] idx);
    return (order == BIT_ORDER_LSB) ? idx : (len - 7'd1 - idx);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCLK half-period tick generator: one tick every i_div+1 enabled cycles
module spi_clk_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_restart,
  input  logic        i_en,
  input  logic [15:0] i_div,
  output logic        o_tick
);

  logic [15:0] r_cnt;

  assign o_tick = i_en && !i_restart && (r_cnt == i_div);

  always_ff @(posedge clk) begin
    if (rst || i_restart || o_tick || !i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master, one symbol per accepted start
// Optional SPI_MASTER_CS_DELAY_EN: adds cs_delay, stretching SETUP and scs deassertion.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic                      scs,
  input  logic [1:0]                mode,
  input  logic                      bit_order,
  input  logic [5:0]                sym_size,
  input  logic [15:0]               clk_div,
  input  logic [DATA_BUS_WIDTH-1:0] dout,
  input  logic                      start,
  input  logic                      keep_cs,
`ifdef SPI_MASTER_CS_DELAY_EN
  input  logic [7:0]                cs_delay,
`endif
  output logic [DATA_BUS_WIDTH-1:0] din,
  output logic                      busy,
  output logic                      next,
  output logic                      stop
);

  localparam int IW = $clog2(DATA_BUS_WIDTH);

  logic [2:0]                r_state;
  logic                      r_cpol, r_cpha, r_order, r_keep;
  logic [6:0]                r_len, r_idx;
  logic [15:0]               r_div;
  logic [DATA_BUS_WIDTH-1:0] r_tx, r_rx, r_din;
  logic                      r_sclk, r_mosi, r_scs, r_busy, r_next, r_stop;
`ifdef SPI_MASTER_CS_DELAY_EN
  logic [7:0]                r_cs_dly, r_hp;
`endif

  logic                      w_accept, w_tick, w_div_en, w_sample, w_last;
  logic [6:0]                w_len_in;
  logic [IW-1:0]             w_first_pos, w_pos, w_next_pos;
  logic [DATA_BUS_WIDTH-1:0] w_rx_next;

  assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_HOLD));
  assign w_len_in    = (sym_size == 6'd0) ? 7'(DATA_BUS_WIDTH) : {1'b0, sym_size};
  assign w_first_pos = IW'(bit_pos(bit_order, w_len_in, 7'd0));
  assign w_pos       = IW'(bit_pos(r_order, r_len, r_idx));
  assign w_next_pos  = IW'(bit_pos(r_order, r_len, r_idx + 7'd1));
  assign w_last      = (r_idx == r_len - 7'd1);
  assign w_div_en    = (r_state == ST_SETUP) || (r_state == ST_LEAD) ||
                       (r_state == ST_TRAIL) || (r_state == ST_CS_OFF);
  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  assign w_sample    = w_tick && (r_cpha ? (r_state == ST_TRAIL) : (r_state == ST_LEAD));

  always_comb begin
    w_rx_next = r_rx;
    if (w_sample) w_rx_next[w_pos] = miso;
  end

  spi_clk_div u_clk_div (
    .clk      (clk),
    .rst      (rst),
    .i_restart(w_accept),
    .i_en     (w_div_en),
    .i_div    (r_div),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      {r_cpol, r_cpha, r_order, r_keep} <= '0;
      r_len <= '0;
      r_idx <= '0;
      r_div <= '0;
      r_tx  <= '0;
      r_rx  <= '0;
      r_din <= '0;
      {r_sclk, r_mosi, r_scs, r_busy, r_next, r_stop} <= '0;
`ifdef SPI_MASTER_CS_DELAY_EN
      r_cs_dly <= '0;
      r_hp     <= '0;
`endif
    end else begin
      r_next <= 1'b0;
      r_stop <= 1'b0;
      r_rx   <= w_rx_next;
      if (w_accept) begin
        r_cpol  <= mode[MODE_CPOL_BIT];
        r_cpha  <= mode[MODE_CPHA_BIT];
        r_order <= bit_order;
        r_len   <= w_len_in;
        r_div   <= clk_div;
        r_keep  <= keep_cs;
        r_tx    <= dout;
        r_rx    <= '0;
        r_idx   <= '0;
        r_busy  <= 1'b1;
        r_scs   <= 1'b1;
        r_sclk  <= mode[MODE_CPOL_BIT];
        r_mosi  <= dout[w_first_pos];
        r_state <= (r_state == ST_HOLD) ? ST_LEAD : ST_SETUP;
`ifdef SPI_MASTER_CS_DELAY_EN
        r_cs_dly <= cs_delay;
        r_hp     <= '0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: r_sclk <= mode[MODE_CPOL_BIT];
          ST_SETUP: begin
`ifdef SPI_MASTER_CS_DELAY_EN
            if (w_tick) begin
              if (r_hp == r_cs_dly) begin
                r_hp    <= '0;
                r_state <= ST_LEAD;
              end else begin
                r_hp <= r_hp + 8'd1;
              end
            end
`else
            if (w_tick) r_state <= ST_LEAD;
`endif
          end
          ST_LEAD: begin
            if (w_tick) begin
              r_sclk  <= ~r_sclk;
              r_state <= ST_TRAIL;
              if (r_cpha) r_mosi <= r_tx[w_pos];
            end
          end
          ST_TRAIL: begin
            if (w_tick) begin
              r_sclk <= ~r_sclk;
              if (w_last) begin
                r_din  <= w_rx_next;
                r_next <= 1'b1;
                if (r_keep) begin
                  r_state <= ST_HOLD;
                  r_busy  <= 1'b0;
                end else begin
`ifdef SPI_MASTER_CS_DELAY_EN
                  r_state <= ST_CS_OFF;
                  r_hp    <= '0;
`else
                  r_state <= ST_IDLE;
                  r_scs   <= 1'b0;
                  r_stop  <= 1'b1;
                  r_busy  <= 1'b0;
`endif
                end
              end else begin
                r_idx   <= r_idx + 7'd1;
                r_state <= ST_LEAD;
                if (!r_cpha) r_mosi <= r_tx[w_next_pos];
              end
            end
          end
`ifdef SPI_MASTER_CS_DELAY_EN
          ST_CS_OFF: begin
            if (w_tick) begin
              if (r_hp == r_cs_dly) begin
                r_state <= ST_IDLE;
                r_scs   <= 1'b0;
                r_stop  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_hp <= r_hp + 8'd1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign scs  = r_scs;
  assign din  = r_din;
  assign busy = r_busy;
  assign next = r_next;
  assign stop = r_stop;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_BUS_WIDTH, default 32, maximum symbol width and width of dout/din.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sclk  output  1  SPI serial clock to the slave.
REQ-005 mosi  output  1  serial data to the slave.
REQ-006 miso  input  1  serial data from the slave.
REQ-007 scs  output  1  chip-select, 1 = selected (board inverts if needed).
REQ-008 mode  input  2  SPI mode 0-3: bit1 = CPOL (idle level), bit0 = CPHA (sample on second edge).
REQ-009 bit_order  input  1  0 = MSB first, 1 = LSB first.
REQ-010 sym_size  input  6  symbol length in bits, legal 1..DATA_BUS_WIDTH.
REQ-011 clk_div  input  16  SCLK half-period = clk_div+1 clk cycles.
REQ-012 dout  input  DATA_BUS_WIDTH  symbol to send; bits above sym_size-1 ignored.
REQ-013 start  input  1  request one symbol; accepted only when busy=0.
REQ-014 keep_cs  input  1  sampled with start; 1 = leave scs asserted after the symbol.
REQ-015 din  output  DATA_BUS_WIDTH  received symbol, right-aligned, upper bits zero.
REQ-016 busy  output  1  high from accept cycle until return to IDLE/HOLD.
REQ-017 next  output  1  one-cycle pulse; din valid on that cycle and held until next accept.
REQ-018 stop  output  1  one-cycle pulse when scs deasserts.

Function
REQ-019 mode, bit_order, sym_size, clk_div, dout and keep_cs shall be latched on the accept cycle; later changes shall not affect the transfer in progress.
REQ-020 States: IDLE (scs=0), SETUP, LEAD (first SCLK edge pending), TRAIL (second edge pending), HOLD (scs=1, idle between symbols).
REQ-021 IDLE/HOLD + start: latch, busy=1; IDLE -> SETUP (scs=1 next cycle), HOLD -> LEAD directly.
REQ-022 SETUP shall last one half-period, then -> LEAD; sclk shall equal CPOL in IDLE, SETUP and HOLD.
REQ-023 Each half-period expiry shall toggle sclk; LEAD -> TRAIL -> LEAD per bit, counting sym_size bits.
REQ-024 CPHA=0: first bit on mosi on accept; miso sampled on leading edge; mosi shifts on trailing edge.
REQ-025 CPHA=1: mosi shifts on leading edge; miso sampled on trailing edge.
REQ-026 bit_order=0: bit sym_size-1 sent first; bit_order=1: bit 0 sent first; received bits placed in same order.
REQ-027 After the last trailing edge: din updated and next pulsed in the same cycle; keep_cs=1 -> HOLD, else scs=0, stop pulse, -> IDLE.
REQ-028 Start asserted while busy=1 shall be ignored; start held high in HOLD shall launch back-to-back symbols with no gap beyond one half-period.
REQ-029 clk_div=0 shall give sclk = clk/2; sym_size=0 shall be treated as DATA_BUS_WIDTH.
REQ-030 start in HOLD with keep_cs=0 latched shall send one more symbol then deassert scs.

Reset
REQ-031 rst shall force IDLE on the next posedge, abort any transfer without a next/stop pulse, and set scs=0, sclk=0, mosi=0, din=0, busy=0, next=0, stop=0.
REQ-032 First cycle after reset, sclk shall follow the current mode CPOL.

Configuration
REQ-033 Macro SPI_MASTER_CS_DELAY_EN: defined adds input cs_delay[7:0], SETUP lasts cs_delay+1 half-periods and an equal delay precedes scs deassertion; undefined keeps fixed one half-period SETUP and immediate deassertion.

Structure
REQ-034 Shared package spi_pkg holds mode encodings, bit_order constants and the state encoding, common with spi_slave.
REQ-035 Sub-module spi_clk_div generates the half-period tick from clk_div, restarted on accept.

Verification
REQ-036 Mode 0, 8-bit, MSB, dout=0xAA, slave model returns 0x42 -> mosi 1,0,1,0,1,0,1,0; din=0x42 with next; stop once.
REQ-037 Modes 1,2,3 with 0xFF/0x00/0x12 vs slave 0xFF/0x00/0xAA -> correct idle level, sample edge and din per mode.
REQ-038 LSB first, dout=0x12 -> mosi 0,1,0,0,1,0,0,0; 16- and 32-bit 0xAAAA/0xAAAAAAAA round-trip exact.
REQ-039 Four symbols with keep_cs=1,1,1,0 -> scs high throughout, four next pulses, one stop.
REQ-040 rst asserted mid-symbol, bit 3 -> outputs at reset values next cycle, no next/stop; fresh 0x5A transfer then correct.
REQ-041 clk_div=0 and clk_div=3 -> sclk half-period 1 and 4 clk cycles; start during busy ignored.
